// File: rtl/prgn_pkg.sv
// -----------------------------------------------------------------------------
// prgn_pkg
// Shared definitions for the PRGN xorshift32 generator and its stream checker.
// Both the generator core and the checker take the next-value function from
// here, so the golden sequence cannot drift away from the produced one.
//
// Contents:
//   NUM_OUT_DEF       default number of beats per seed
//   XS_A/XS_B/XS_C    xorshift32 shift amounts (13 / 17 / 5)
//   err_code_t        first-error codes reported by the checker
//   state_t, ST_*     checker FSM state encoding
//   nxt()             one xorshift32 step
// -----------------------------------------------------------------------------
package prgn_pkg;

    localparam int NUM_OUT_DEF = 256;

    localparam int XS_A = 13;
    localparam int XS_B = 17;
    localparam int XS_C = 5;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,  // no error seen
        ERR_DATA    = 3'd1,  // beat data differs from the local sequence
        ERR_TIMEOUT = 3'd2,  // too many idle clocks before/between beats
        ERR_EARLY   = 3'd3,  // beat arrived before any seed
        ERR_EXTRA   = 3'd4,  // beat arrived after the run completed
        ERR_SEED    = 3'd5   // seed strobe while a run was in progress
    } err_code_t;

    // Plain constants keep the encoding readable in older tools and waveforms.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_REPORT = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // One xorshift32 step; every shift truncates to 32 bits.
    function automatic logic [31:0] nxt(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << XS_A);
        y = y ^ (y >> XS_B);
        y = y ^ (y << XS_C);
        return y;
    endfunction

endpackage

// File: rtl/prgn_xs32_step.sv
// -----------------------------------------------------------------------------
// prgn_xs32_step
// Purely combinational xorshift32 step, a thin wrapper around prgn_pkg::nxt().
//
// Ports:
//   cur      in   32  current sequence value
//   nxt_val  out  32  next sequence value
// -----------------------------------------------------------------------------
module prgn_xs32_step
    import prgn_pkg::*;
(
    input  logic [31:0] cur,
    output logic [31:0] nxt_val
);

    assign nxt_val = nxt(cur);

endmodule

// File: rtl/prgn_stream_checker.sv
// -----------------------------------------------------------------------------
// prgn_stream_checker
// Consumer-side checker for the PRGN output stream. A seed is taken once, the
// xorshift32 sequence is regenerated locally and every beat is compared with
// it. Reports busy, a done pulse, sticky pass/fail, the first error code and
// the beat index of that first error, plus the number of beats accepted.
//
// Ports:
//   clk         in   1      clock (output domain)
//   rst_n       in   1      synchronous active-low reset
//   seed_valid  in   1      one-cycle seed strobe
//   seed        in   32     seed value
//   out_valid   in   1      beat strobe
//   rand_num    in   32     beat data
//   busy        out  1      a run is being checked
//   done        out  1      one-cycle pulse when a run ends
//   pass        out  1      sticky: last run ended with no error
//   fail        out  1      sticky: an error was seen in this run
//   err_code    out  3      first error code (see prgn_pkg::err_code_t)
//   err_idx     out  CNT_W  beat index at which the first error occurred
//   beat_cnt    out  CNT_W  beats accepted in this run (saturating)
// -----------------------------------------------------------------------------
module prgn_stream_checker
    import prgn_pkg::*;
#(
    parameter int NUM_OUT = NUM_OUT_DEF,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_valid,
    input  logic [31:0]      seed,
    input  logic             out_valid,
    input  logic [31:0]      rand_num,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] err_idx,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [31:0]      exp_val;    // value the next beat must carry
    logic [TMR_W-1:0] tmr;        // idle clocks since seed or last beat

    logic [31:0]      step_in;
    logic [31:0]      step_out;
    logic [CNT_W-1:0] cnt_inc;
    logic             start;
    logic             beat_last;
    logic             tmr_hit;
    err_code_t        ev_code;    // error raised by this cycle's inputs

    // One step unit serves both the seed load and the per-beat advance: the
    // two never happen in the same cycle.
    prgn_xs32_step u_step (
        .cur     (step_in),
        .nxt_val (step_out)
    );

    // Both decode registered state, so they are glitch-free and line up with
    // the cycle after the triggering input.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_REPORT);

    // NOTE: every variable gets a default at the top of the block so no
    // path leaves one unassigned, which would infer a latch.
    always_comb begin
        start     = seed_valid && (state != ST_RUN);
        step_in   = start ? seed : exp_val;
        cnt_inc   = (beat_cnt == {CNT_W{1'b1}}) ? beat_cnt : beat_cnt + CNT_W'(1);
        beat_last = out_valid && (cnt_inc == CNT_W'(NUM_OUT));
        tmr_hit   = !out_valid && (tmr == TMR_W'(TIMEOUT - 1));
        ev_code   = ERR_NONE;

        if (state == ST_RUN) begin
            // A bad beat outranks a stray seed or timeout in the same cycle.
            if (out_valid && (rand_num != exp_val)) begin
                ev_code = ERR_DATA;
            end else if (seed_valid) begin
                ev_code = ERR_SEED;
            end else if (tmr_hit) begin
                ev_code = ERR_TIMEOUT;
            end
        end else if (out_valid) begin
            // A beat sharing its cycle with a new seed still predates the run.
            ev_code = (start || (state == ST_IDLE)) ? ERR_EARLY : ERR_EXTRA;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            exp_val  <= '0;
            tmr      <= '0;
            beat_cnt <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            err_code <= ERR_NONE;
            err_idx  <= '0;
        end else if (start) begin
            // New run from IDLE, REPORT or DONE; status restarts from clean,
            // except that a beat in this same cycle is the run's first error.
            state    <= ST_RUN;
            exp_val  <= step_out;
            tmr      <= '0;
            beat_cnt <= '0;
            pass     <= 1'b0;
            fail     <= out_valid;
            err_code <= ev_code;
            err_idx  <= '0;
        end else begin
            if (ev_code != ERR_NONE) begin
                fail <= 1'b1;
                if (err_code == ERR_NONE) begin
                    err_code <= ev_code;
                    err_idx  <= beat_cnt;
                end
            end

            case (state)
                ST_RUN: begin
                    if (out_valid) begin
                        exp_val  <= step_out;
                        beat_cnt <= cnt_inc;
                        tmr      <= '0;
                    end else if (tmr != {TMR_W{1'b1}}) begin
                        tmr <= tmr + TMR_W'(1);
                    end

                    // pass must already include an error raised by the very
                    // beat (or timeout) that ends the run.
                    if (beat_last || tmr_hit) begin
                        state <= ST_REPORT;
                        pass  <= !fail && (ev_code == ERR_NONE);
                    end
                end

                ST_REPORT: begin
                    state <= ST_DONE;
                    if (out_valid) pass <= 1'b0;
                end

                default: begin
                    // IDLE and DONE: status holds; any beat is an error.
                    if (out_valid) pass <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prgn_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_prgn_stream_checker
// Self-checking bench for prgn_stream_checker: hand sequences for reset, early
// and extra beats, timeout and mid-run reset; a table of run scenarios; and
// random runs whose expected status comes from a small event-ordering model.
// -----------------------------------------------------------------------------
module tb_prgn_stream_checker;

    localparam int NUM_OUT = 256;
    localparam int TIMEOUT = 1000;
    localparam int CNT_W   = 9;
    localparam int NO_EVT  = -1;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             seed_valid = 1'b0;
    logic [31:0]      seed       = '0;
    logic             out_valid  = 1'b0;
    logic [31:0]      rand_num   = '0;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] err_idx;
    logic [CNT_W-1:0] beat_cnt;

    int n_checks  = 0;
    int n_errors  = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    prgn_stream_checker #(
        .NUM_OUT (NUM_OUT),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed       (seed),
        .out_valid  (out_valid),
        .rand_num   (rand_num),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .err_code   (err_code),
        .err_idx    (err_idx),
        .beat_cnt   (beat_cnt)
    );

    typedef struct {
        logic [31:0] seed;
        int          bad_at;    // beat whose data is corrupted, NO_EVT for none
        logic [31:0] mask;      // XOR applied to the corrupted beat
        int          stray_at;  // stray seed in the gap before this beat
        bit          exp_pass;
        logic [2:0]  exp_code;
        int          exp_idx;
    } scn_t;

    scn_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
    endtask

    // Reference sequence straight from the xorshift32 rules.
    function automatic logic [31:0] tb_xs(input logic [31:0] v);
        logic [31:0] t;
        t = v;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // First error of a run = earliest event in time. A stray seed sits in the
    // gap before its beat, so it precedes a corruption of that same beat.
    function automatic void model_first_err(input int bad_at, input int stray_at,
                                            output logic [2:0] code, output int idx);
        int t_bad;
        int t_stray;
        t_bad   = (bad_at   >= 0) ? 2 * bad_at + 1 : 32'h3fff_ffff;
        t_stray = (stray_at >= 0) ? 2 * stray_at   : 32'h3fff_ffff;
        code = 3'd0;
        idx  = 0;
        if (t_stray < t_bad) begin
            code = 3'd5;
            idx  = stray_at;
        end else if (bad_at >= 0) begin
            code = 3'd1;
            idx  = bad_at;
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_pass"},     32'(pass),     32'd0);
        check({tag, "_fail"},     32'(fail),     32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_err_idx"},  32'(err_idx),  32'd0);
        check({tag, "_beat_cnt"}, 32'(beat_cnt), 32'd0);
    endtask

    // Full run: seed, NUM_OUT beats with 0-3 idle gaps, then the report.
    task automatic run_scn(input string tag, input scn_t s);
        logic [31:0] exp_q [$];
        logic [31:0] x;
        int          done0;
        int          gap;

        x = s.seed;
        for (int i = 0; i < NUM_OUT; i++) begin
            x = tb_xs(x);
            exp_q.push_back(x);
        end

        seed       = s.seed;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        done0      = done_seen;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_fail_clear"}, 32'(fail), 32'd0);

        for (int b = 0; b < NUM_OUT; b++) begin
            gap = $urandom_range(0, 3);
            if (b == s.stray_at && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
                if (b == s.stray_at && g == 0) begin
                    seed       = $urandom;
                    seed_valid = 1'b1;
                end
                tick();
                if (seed_valid) begin
                    seed_valid = 1'b0;
                    check({tag, "_stray_fail"}, 32'(fail), 32'd1);
                end
            end
            out_valid = 1'b1;
            rand_num  = (b == s.bad_at) ? (exp_q[b] ^ s.mask) : exp_q[b];
            tick();
            out_valid = 1'b0;
            if (b == s.bad_at) check({tag, "_bad_fail"}, 32'(fail), 32'd1);
        end

        check({tag, "_done"},     32'(done),     32'd1);
        check({tag, "_busy_end"}, 32'(busy),     32'd0);
        check({tag, "_pass"},     32'(pass),     32'(s.exp_pass));
        check({tag, "_fail"},     32'(fail),     32'(!s.exp_pass));
        check({tag, "_err_code"}, 32'(err_code), 32'(s.exp_code));
        check({tag, "_err_idx"},  32'(err_idx),  32'(s.exp_idx));
        check({tag, "_beat_cnt"}, 32'(beat_cnt), 32'(NUM_OUT));
        tick();
        check({tag, "_done_low"},  32'(done),              32'd0);
        check({tag, "_done_once"}, 32'(done_seen - done0), 32'd1);
        check({tag, "_pass_hold"}, 32'(pass),              32'(s.exp_pass));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] x;
        logic [2:0]  m_code;
        int          m_idx;
        int          n;
        int          d0;
        int          r_bad;
        int          r_stray;
        scn_t        rs;

        tbl[0] = '{32'h0000_0001, NO_EVT, 32'h0,         NO_EVT, 1'b1, 3'd0, 0};
        tbl[1] = '{32'h0000_0001, 5,      32'h1,         NO_EVT, 1'b0, 3'd1, 5};
        tbl[2] = '{32'h0000_0001, NO_EVT, 32'h0,         10,     1'b0, 3'd5, 10};
        tbl[3] = '{$urandom,      255,    32'h8000_0000, NO_EVT, 1'b0, 3'd1, 255};
        tbl[4] = '{$urandom,      0,      32'h0000_0100, NO_EVT, 1'b0, 3'd1, 0};
        tbl[5] = '{$urandom,      3,      32'h0000_0004, 7,      1'b0, 3'd1, 3};
        tbl[6] = '{$urandom,      20,     32'h0000_0001, 12,     1'b0, 3'd5, 12};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Beat before any seed, then a clean run that clears it
        out_valid = 1'b1;
        rand_num  = 32'h0004_2021;
        tick();
        out_valid = 1'b0;
        check("early_fail", 32'(fail),     32'd1);
        check("early_code", 32'(err_code), 32'd3);
        check("early_busy", 32'(busy),     32'd0);
        run_scn("after_early", tbl[0]);

        // Extra beat after a passing run
        out_valid = 1'b1;
        rand_num  = $urandom;
        tick();
        out_valid = 1'b0;
        check("extra_pass",     32'(pass),     32'd0);
        check("extra_fail",     32'(fail),     32'd1);
        check("extra_code",     32'(err_code), 32'd4);
        check("extra_idx",      32'(err_idx),  32'(NUM_OUT));
        check("extra_beat_cnt", 32'(beat_cnt), 32'(NUM_OUT));

        // Scenario table
        for (int i = 0; i < 7; i++) begin
            run_scn($sformatf("tbl%0d", i), tbl[i]);
        end

        // Random runs checked against the event-ordering model
        for (int r = 0; r < 3; r++) begin
            r_bad   = $urandom_range(0, NUM_OUT);
            r_stray = $urandom_range(0, 2 * NUM_OUT);
            if (r_bad == NUM_OUT) r_bad = NO_EVT;
            if (r_stray >= NUM_OUT) r_stray = NO_EVT;
            model_first_err(r_bad, r_stray, m_code, m_idx);
            rs = '{$urandom, r_bad, 32'(1) << $urandom_range(0, 31), r_stray,
                   (m_code == 3'd0), m_code, m_idx};
            run_scn($sformatf("rnd%0d", r), rs);
        end

        // Timeout with no beats at all
        seed       = 32'h0000_0001;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 3 * TIMEOUT) begin
            tick();
            n++;
        end
        check("timeout_latency",  32'(n),        32'(TIMEOUT + 1));
        check("timeout_fail",     32'(fail),     32'd1);
        check("timeout_code",     32'(err_code), 32'd2);
        check("timeout_idx",      32'(err_idx),  32'd0);
        check("timeout_pass",     32'(pass),     32'd0);
        check("timeout_beat_cnt", 32'(beat_cnt), 32'd0);

        // Reset at beat 100 of a run that already holds an error at beat 50
        seed       = 32'h0000_0001;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        x         = 32'h0004_2021;
        out_valid = 1'b1;
        rand_num  = x;
        tick();
        check("first_beat_ok", 32'(fail), 32'd0);
        for (int b = 1; b < 100; b++) begin
            x        = tb_xs(x);
            rand_num = (b == 50) ? (x ^ 32'h10) : x;
            tick();
        end
        out_valid = 1'b0;
        check("pre_reset_code",     32'(err_code), 32'd1);
        check("pre_reset_idx",      32'(err_idx),  32'd50);
        check("pre_reset_beat_cnt", 32'(beat_cnt), 32'd100);
        d0    = done_seen;
        rst_n = 1'b0;
        tick();
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        repeat (5) tick();
        check("mid_reset_no_done", 32'(done_seen - d0), 32'd0);
        check("mid_reset_idle",    32'(busy),           32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
